// File: rtl/pa_in_sched_pkg.sv
// Shared definitions for the pa_in_sched capture scheduler.
// Holds the requester count, datapath config-RAM addresses and FSM state encoding.
package pa_in_sched_pkg;

  localparam int unsigned PA_NUM_REQ = 4;

  // Datapath config-RAM addresses driven on cs_addr.
  localparam logic [2:0] PA_CS_IDLE = 3'b000;  // hold
  localparam logic [2:0] PA_CS_COPY = 3'b001;  // PI -> A0

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCopy  = 2'd1,
    StPush  = 2'd2,
    StStall = 2'd3
  } pa_state_e;

endpackage

// File: rtl/pa_in_sched_rr_arb.sv
// pa_rr_arb: combinational rotate-priority arbiter.
// Ports:
//   req  - per-source request bits
//   ptr  - index where the priority search starts (wraps 3 -> 0)
//   any  - at least one request is set
//   win  - index of the first set request at or after ptr
module pa_rr_arb
  import pa_in_sched_pkg::*;
(
  input  logic [PA_NUM_REQ-1:0] req,
  input  logic [1:0]            ptr,
  output logic                  any,
  output logic [1:0]            win
);

  logic [1:0] idx;

  always_comb begin
    any = 1'b0;
    win = ptr;
    idx = ptr;
    for (int unsigned i = 0; i < PA_NUM_REQ; i++) begin
      idx = ptr + 2'(i);  // 2-bit add wraps the search naturally
      if (!any && req[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
  end

endmodule

// File: rtl/pa_in_sched.sv
// pa_in_sched: round-robin scheduler sharing one UDB capture datapath
// (PI -> A0 -> FIFO0) among four byte sources.
// Ports:
//   clock, reset            - datapath clock, asynchronous active-high reset
//   en                      - scheduler enable (gates new grants and dma)
//   req, req_data           - per-source request and byte (source i at [8i+7:8i])
//   gnt                     - one-hot grant pulse in the capture (COPY) cycle
//   pi, cs_addr, f0_load    - datapath parallel input, config address, FIFO0 load
//   f0_full, f0_bus_stat    - FIFO0 full and DMA status from the datapath
//   dma                     - f0_bus_stat gated by en
//   burst_cnt, burst_done   - bytes pushed in current burst, burst completion pulse
module pa_in_sched
  import pa_in_sched_pkg::*;
#(
  parameter int unsigned BURST_LEN = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    en,
  input  logic [PA_NUM_REQ-1:0]   req,
  input  logic [8*PA_NUM_REQ-1:0] req_data,
  output logic [PA_NUM_REQ-1:0]   gnt,
  output logic [7:0]              pi,
  output logic [2:0]              cs_addr,
  output logic                    f0_load,
  input  logic                    f0_full,
  input  logic                    f0_bus_stat,
  output logic                    dma,
  output logic [7:0]              burst_cnt,
  output logic                    burst_done
);

  localparam logic [7:0] BurstLenB = 8'(BURST_LEN);

  pa_state_e  state;
  logic [1:0] ptr;
  logic [1:0] win_q;
  logic       arb_any;
  logic [1:0] arb_win;
  logic [7:0] win_byte;
  logic [7:0] cnt_next;

  pa_rr_arb u_arb (
    .req (req),
    .ptr (ptr),
    .any (arb_any),
    .win (arb_win)
  );

  always_comb begin
    win_byte = req_data[{arb_win, 3'b000} +: 8];
    cnt_next = burst_cnt + 8'd1;
    dma      = f0_bus_stat & en;
  end

  // Outputs are registered: each state's outputs are loaded on the edge that enters it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      ptr        <= 2'd0;
      win_q      <= 2'd0;
      pi         <= 8'h00;
      gnt        <= '0;
      cs_addr    <= PA_CS_IDLE;
      f0_load    <= 1'b0;
      burst_cnt  <= 8'd0;
      burst_done <= 1'b0;
    end else begin
      gnt        <= '0;
      cs_addr    <= PA_CS_IDLE;
      f0_load    <= 1'b0;
      burst_done <= 1'b0;
      case (state)
        StIdle: begin
          if (en && arb_any) begin
            if (!f0_full) begin
              win_q   <= arb_win;
              pi      <= win_byte;
              gnt     <= PA_NUM_REQ'(1) << arb_win;
              cs_addr <= PA_CS_COPY;
              state   <= StCopy;
            end else begin
              state <= StStall;
            end
          end
        end
        StStall: begin
          if (!f0_full) state <= StIdle;
        end
        // f0_full is ignored from here on: the FIFO reserves one slot of slack.
        StCopy: begin
          f0_load <= 1'b1;
          ptr     <= win_q + 2'd1;
          if (cnt_next == BurstLenB) begin
            burst_cnt  <= 8'd0;
            burst_done <= 1'b1;
          end else begin
            burst_cnt <= cnt_next;
          end
          state <= StPush;
        end
        StPush: state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pa_in_sched.sv
// Self-checking bench for pa_in_sched: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_pa_in_sched;

  localparam int BL = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic        f0_full = 1'b0;
  logic        f0_bus_stat = 1'b0;

  logic [3:0] gnt, gnt1;
  logic [7:0] pi, pi1;
  logic [2:0] cs_addr, cs_addr1;
  logic       f0_load, f0_load1;
  logic       dma, dma1;
  logic [7:0] burst_cnt, burst_cnt1;
  logic       burst_done, burst_done1;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pa_in_sched #(.BURST_LEN(BL)) u_dut (
    .clock(clock), .reset(reset), .en(en), .req(req), .req_data(req_data),
    .gnt(gnt), .pi(pi), .cs_addr(cs_addr), .f0_load(f0_load), .f0_full(f0_full),
    .f0_bus_stat(f0_bus_stat), .dma(dma), .burst_cnt(burst_cnt), .burst_done(burst_done)
  );

  pa_in_sched #(.BURST_LEN(1)) u_dut1 (
    .clock(clock), .reset(reset), .en(en), .req(req), .req_data(req_data),
    .gnt(gnt1), .pi(pi1), .cs_addr(cs_addr1), .f0_load(f0_load1), .f0_full(f0_full),
    .f0_bus_stat(f0_bus_stat), .dma(dma1), .burst_cnt(burst_cnt1),
    .burst_done(burst_done1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return 0;
  endfunction

  // Model: a transfer is "age 1" in its grant cycle and "age 2" in its load cycle.
  int         m_age, m_ptr, m_win, m_cnt4;
  logic       m_stall, m_done4, m_done1;
  logic [7:0] m_pi;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_age <= 0; m_stall <= 1'b0; m_ptr <= 0; m_win <= 0; m_pi <= 8'h00;
      m_cnt4 <= 0; m_done4 <= 1'b0; m_done1 <= 1'b0;
    end else begin
      m_done4 <= 1'b0;
      m_done1 <= 1'b0;
      if (m_age == 1) begin
        m_age   <= 2;
        m_ptr   <= (m_win + 1) % 4;
        m_cnt4  <= (m_cnt4 + 1) % BL;
        m_done4 <= (m_cnt4 + 1 == BL);
        m_done1 <= 1'b1;
      end else if (m_age == 2) begin
        m_age <= 0;
      end else if (m_stall) begin
        if (!f0_full) m_stall <= 1'b0;
      end else if (en && req != 4'b0) begin
        if (!f0_full) begin
          m_win <= pick(req, m_ptr);
          m_pi  <= req_data[8 * pick(req, m_ptr) +: 8];
          m_age <= 1;
        end else begin
          m_stall <= 1'b1;
        end
      end
    end
  end

  always @(negedge clock) begin
    logic [3:0] eg;
    eg = (m_age == 1) ? (4'b0001 << m_win) : 4'b0000;
    chk("gnt", {28'd0, gnt}, {28'd0, eg});
    chk("gnt_bl1", {28'd0, gnt1}, {28'd0, eg});
    chk("cs_addr", {29'd0, cs_addr}, (m_age == 1) ? 32'd1 : 32'd0);
    chk("f0_load", {31'd0, f0_load}, (m_age == 2) ? 32'd1 : 32'd0);
    chk("f0_load_bl1", {31'd0, f0_load1}, (m_age == 2) ? 32'd1 : 32'd0);
    chk("pi", {24'd0, pi}, {24'd0, m_pi});
    chk("burst_cnt", {24'd0, burst_cnt}, m_cnt4);
    chk("burst_done", {31'd0, burst_done}, {31'd0, m_done4});
    chk("burst_cnt_bl1", {24'd0, burst_cnt1}, 32'd0);
    chk("burst_done_bl1", {31'd0, burst_done1}, {31'd0, m_done1});
    chk("dma", {31'd0, dma}, {31'd0, f0_bus_stat & en});
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  initial begin
    logic [3:0] fair_g [5];
    logic [7:0] fair_p [5];
    logic [7:0] wrap_c [8];
    fair_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    fair_p = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    wrap_c = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0};

    // Reset values
    cyc(2);
    chk("rst_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_cs", {29'd0, cs_addr}, 32'd0);
    chk("rst_load", {31'd0, f0_load}, 32'd0);
    chk("rst_pi", {24'd0, pi}, 32'd0);
    chk("rst_cnt", {24'd0, burst_cnt}, 32'd0);
    chk("rst_done", {31'd0, burst_done}, 32'd0);
    reset = 1'b0;

    // Single requester
    en = 1'b1; req = 4'b0001; req_data = 32'h0000_00A5;
    cyc(1);
    chk("single_gnt", {28'd0, gnt}, 32'h1);
    chk("single_pi", {24'd0, pi}, 32'hA5);
    chk("single_cs", {29'd0, cs_addr}, 32'h1);
    req = 4'b0000;
    cyc(1);
    chk("single_load", {31'd0, f0_load}, 32'h1);
    chk("single_cnt", {24'd0, burst_cnt}, 32'h1);
    chk("single_done_bl1", {31'd0, burst_done1}, 32'h1);
    cyc(2);

    // Fairness from a fresh pointer
    reset = 1'b1; cyc(1); reset = 1'b0;
    req = 4'b1111; req_data = 32'h4433_2211;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("fair_gnt", {28'd0, gnt}, {28'd0, fair_g[i]});
      chk("fair_pi", {24'd0, pi}, {24'd0, fair_p[i]});
      if (i == 4) req = 4'b0000;
      cyc(2);
    end

    // Burst wrap with BURST_LEN = 4
    reset = 1'b1; cyc(1); reset = 1'b0;
    req = 4'b0001; req_data = 32'h0000_005A;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk("wrap_gnt", {28'd0, gnt}, 32'h1);
      cyc(1);
      chk("wrap_load", {31'd0, f0_load}, 32'h1);
      chk("wrap_cnt", {24'd0, burst_cnt}, {24'd0, wrap_c[i]});
      chk("wrap_done", {31'd0, burst_done}, (i == 3 || i == 7) ? 32'h1 : 32'h0);
      cyc(1);
    end
    req = 4'b0000;
    cyc(1);

    // FIFO full: stall, then release; full rising during COPY still pushes
    f0_full = 1'b1; req = 4'b0100; req_data = 32'h00C3_0000;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("stall_gnt", {28'd0, gnt}, 32'h0);
      chk("stall_load", {31'd0, f0_load}, 32'h0);
    end
    f0_full = 1'b0;
    cyc(1);
    chk("stall_exit_gnt", {28'd0, gnt}, 32'h0);
    cyc(1);
    chk("stall_gnt_after", {28'd0, gnt}, 32'h4);
    chk("stall_pi", {24'd0, pi}, 32'hC3);
    f0_full = 1'b1; req = 4'b0000;
    cyc(1);
    chk("full_in_copy_load", {31'd0, f0_load}, 32'h1);
    f0_full = 1'b0;
    cyc(1);

    // en falls during COPY (pointer is 3, only source 0 requests)
    req = 4'b0001; req_data = 32'h0000_0077;
    cyc(1);
    chk("en_gnt", {28'd0, gnt}, 32'h1);
    en = 1'b0;
    cyc(1);
    chk("en_push", {31'd0, f0_load}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("en_off_gnt", {28'd0, gnt}, 32'h0);
    end
    en = 1'b1;
    cyc(1);
    chk("en_back_gnt", {28'd0, gnt}, 32'h1);

    // Reset during COPY; pointer (1 here) must return to 0
    #1 reset = 1'b1;
    #1;
    chk("rst_copy_cs", {29'd0, cs_addr}, 32'h0);
    chk("rst_copy_gnt", {28'd0, gnt}, 32'h0);
    chk("rst_copy_load", {31'd0, f0_load}, 32'h0);
    cyc(1);
    req = 4'b0011; req_data = 32'h0000_BBAA;
    reset = 1'b0;
    cyc(1);
    chk("rst_ptr_gnt", {28'd0, gnt}, 32'h1);
    chk("rst_ptr_pi", {24'd0, pi}, 32'hAA);
    req = 4'b0000;
    cyc(3);

    // DMA gating
    f0_bus_stat = 1'b1; en = 1'b1;
    #1 chk("dma_on", {31'd0, dma}, 32'h1);
    en = 1'b0;
    #1 chk("dma_off", {31'd0, dma}, 32'h0);
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
